// File: rtl/serial_adder.sv
// serial_adder: bit-serial LSB-first adder; one bit per clock in RUN,
// result published on entry to a one-cycle DONE state.
module serial_adder #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             c,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] sum,
    output logic             carry
);
    localparam int CW = $clog2(WIDTH) + 1;

    typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

    state_t           state;
    logic [WIDTH-1:0] a_sr;
    logic [WIDTH-1:0] b_sr;
    logic [WIDTH-1:0] res;
    logic [CW-1:0]    cnt;
    logic             cy;
    logic             s;
    logic             cout;

    assign s    = a_sr[0] ^ b_sr[0] ^ cy;
    assign cout = (a_sr[0] & b_sr[0]) | (b_sr[0] & cy) | (cy & a_sr[0]);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
            a_sr  <= '0;
            b_sr  <= '0;
            res   <= '0;
            cnt   <= '0;
            cy    <= 1'b0;
            busy  <= 1'b0;
            done  <= 1'b0;
            sum   <= '0;
            carry <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    done <= 1'b0;
                    if (start) begin
                        a_sr  <= a;
                        b_sr  <= b;
                        cy    <= c;
                        cnt   <= '0;
                        busy  <= 1'b1;
                        state <= RUN;
                    end
                end
                RUN: begin
                    a_sr <= a_sr >> 1;
                    b_sr <= b_sr >> 1;
                    res  <= {s, res[WIDTH-1:1]};
                    cy   <= cout;
                    cnt  <= cnt + CW'(1);
                    // last bit: publish the result formed by this edge's shift
                    if (cnt == CW'(WIDTH - 1)) begin
                        sum   <= {s, res[WIDTH-1:1]};
                        carry <= cout;
                        busy  <= 1'b0;
                        done  <= 1'b1;
                        state <= DONE;
                    end
                end
                DONE: begin
                    done  <= 1'b0;
                    state <= IDLE;
                end
                default: begin
                    busy  <= 1'b0;
                    done  <= 1'b0;
                    state <= IDLE;
                end
            endcase
        end
    end
endmodule
